raster_addr_gen: RTL
====================

// Module: raster_addr_gen
// PURPOSE
//  Parametrised frame-buffer address generator, next generation of the row/col address mux.
//  On a start pulse it scans a H_ACTIVE x V_ACTIVE raster and emits one byte address per pixel.
//  addr = base + row*stride + col_term. Stride and col_term are selected by a runtime pixel-packing mode.
//  Output uses a valid/ready handshake. Sits between the capture/display timing logic and the SRAM/SDRAM controller.
// PARAMETERS
//  H_ACTIVE  800  pixels per line; must be even
//  V_ACTIVE  480  lines per frame
//  COL_W     10   col counter width; 2**COL_W >= H_ACTIVE
//  ROW_W     9    row counter width; 2**ROW_W >= V_ACTIVE
//  ADDR_W    20   address width; all arithmetic is modulo 2**ADDR_W
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       synchronous reset, active-high
//  start      in   1       1-cycle pulse; begins a frame; ignored while busy
//  abort      in   1       synchronous flush back to IDLE; no frame_done
//  mode       in   2       00=8bpp, 01=12bpp packed, 10=16bpp, 11=reserved (treated as 00); sampled on start
//  base       in   ADDR_W  frame base address; sampled on start
//  out_valid  out  1       addr/out_* fields are valid
//  out_ready  in   1       consumer accepts the beat when out_valid && out_ready
//  addr       out  ADDR_W  byte address of the pixel
//  out_row    out  ROW_W   pixel row
//  out_col    out  COL_W   pixel col
//  out_phase  out  1       mode 01: col[0] (pixel starts mid-byte); other modes: 0
//  out_last   out  1       set on the final pixel of the frame
//  busy       out  1       state != IDLE
//  frame_done out  1       1-cycle pulse after the last beat is accepted
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pipeline empty. abort has the same effect, except that it does not clear the latched mode/base.
//  FSM states
//   IDLE : start -> SCAN; latch mode and base.
//   SCAN : on each pipeline-enabled cycle, issue (row,col) in raster order; col is the fast index.
//          Issuing (V_ACTIVE-1, H_ACTIVE-1) -> DRAIN.
//   DRAIN: when the out_last beat is accepted -> IDLE, and frame_done=1 on the following cycle.
//  Pipeline
//   Three stages: S0 scanner register, S1 products, S2 output register.
//   Global enable en = !out_valid || out_ready; all stages hold when en=0.
//   Bubbles are not collapsed.
//   Latency: start sampled at edge T, out_valid=1 after edge T+3.
//   With out_ready held at 1, throughput is 1 beat/cycle and there are no gaps inside a frame.
//  Arithmetic, with H = H_ACTIVE
//   mode 00: stride = H,       col_term = col
//   mode 01: stride = H + H/2, col_term = col + (col>>1)
//   mode 10: stride = 2H,      col_term = col<<1
//   S1 registers row*stride and col_term at full width. S2 registers base + both, truncated to ADDR_W (wrap).
//  Handshake
//   out_* fields stay stable while out_valid && !out_ready.
//   out_valid never drops without acceptance, except on rst/abort.
//  Boundaries
//   Line wrap: col = H-1 -> col 0, row+1. Last pixel -> scanner stops and out_last travels with that beat.
//   start while busy: ignored. start and abort in the same cycle: abort wins, remain IDLE.
//   Back-to-back frames: start is accepted in the cycle frame_done is high (state is IDLE).
//   rst or abort mid-frame: out_valid=0 on the next cycle and the remaining beats are discarded.
//   mode/base changes mid-frame have no effect until the next start.
// STRUCTURE
//  Package raster_addr_pkg holds:
//   - mode_t enum (MODE_8BPP, MODE_12BPP, MODE_16BPP)
//   - state_t enum (IDLE, SCAN, DRAIN)
//   - function stride_of(mode, H)
//  Sub-module addr_calc: the S1/S2 arithmetic with an enable input and pass-through sideband (row, col, last, phase).
//  The top level holds the FSM, scanner counters and handshake.
// TESTING
//  1. Defaults, mode 01, base 0, out_ready=1: (0,0)->0, (0,1)->1 phase1, (0,2)->3, (1,0)->1200, (479,799)->575998 last; then frame_done.
//  2. H=8, V=4, mode 10, base 0x100: 32 beats, addrs 0x100 + 16r + 2c, out_last only on beat 32.
//     First out_valid 3 cycles after start.
//  3. Random out_ready ~50%: every beat appears exactly once in order and fields stay stable while stalled; scoreboard against the model.
//  4. base = 2**ADDR_W-4, mode 00: (0,3)->2**ADDR_W-1, (0,4)->0 (wrap).
//  5. abort at beat 10, then start next cycle: out_valid drops, no frame_done, new frame begins at (0,0).
//     Also: start pulsed while busy is ignored.
//  6. rst mid-frame, with mode=11: all outputs 0 after reset; the following frame generates mode 00 addresses.

Source files
------------

// File: rtl/raster_addr_pkg.sv
// raster_addr_pkg: shared pixel-packing modes, scan states and stride helper
package raster_addr_pkg;
  typedef enum logic [1:0] {MODE_8BPP = 2'b00, MODE_12BPP = 2'b01, MODE_16BPP = 2'b10} mode_t;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
  function automatic int unsigned stride_of(mode_t mode, int unsigned h);
    return mode == MODE_12BPP ? h + h / 2 : mode == MODE_16BPP ? 2 * h : h;
  endfunction
  // the reserved encoding behaves as plain 8bpp
  function automatic mode_t mode_of(logic [1:0] m);
    return m == 2'b11 ? MODE_8BPP : mode_t'(m);
  endfunction
endpackage

// File: rtl/raster_addr_gen_addr_calc.sv
// addr_calc: S1 products and S2 address sum with pass-through sideband
module addr_calc
  import raster_addr_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 800,
  parameter int COL_W = 10,
  parameter int ROW_W = 9,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  mode_t             mode,
  input  logic [ADDR_W-1:0] base,
  input  logic              in_valid,
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  input  logic              last,
  output logic              out_valid,
  output logic [ADDR_W-1:0] addr,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic              out_phase,
  output logic              out_last
);
  localparam int SW = $clog2(2 * H_ACTIVE + 1);
  localparam int PW = ROW_W + SW;
  localparam int TW = COL_W + 1;
  localparam int SUM_W = (PW > ADDR_W ? PW : ADDR_W) + 2;
  logic [SW-1:0] stride;
  logic [TW-1:0] cterm_d, cterm_q;
  logic [PW-1:0] prod_q;
  logic [SUM_W-1:0] sum;
  logic s1_valid, s1_last, s1_phase;
  logic [ROW_W-1:0] s1_row;
  logic [COL_W-1:0] s1_col;
  always_comb begin
    stride = SW'(stride_of(mode, H_ACTIVE));
    cterm_d = mode == MODE_12BPP ? TW'(col) + TW'(col >> 1) : mode == MODE_16BPP ? {col, 1'b0} : TW'(col);
    sum = SUM_W'(base) + SUM_W'(prod_q) + SUM_W'(cterm_q);
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      s1_valid <= 1'b0;
      prod_q <= '0;
      cterm_q <= '0;
      s1_row <= '0;
      s1_col <= '0;
      s1_last <= 1'b0;
      s1_phase <= 1'b0;
      out_valid <= 1'b0;
      addr <= '0;
      out_row <= '0;
      out_col <= '0;
      out_phase <= 1'b0;
      out_last <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      prod_q <= PW'(row) * PW'(stride);
      cterm_q <= cterm_d;
      s1_row <= row;
      s1_col <= col;
      s1_last <= last;
      s1_phase <= mode == MODE_12BPP && col[0];
      out_valid <= s1_valid;
      addr <= sum[ADDR_W-1:0];
      out_row <= s1_row;
      out_col <= s1_col;
      out_phase <= s1_phase;
      out_last <= s1_last;
    end
  end
endmodule

// File: rtl/raster_addr_gen.sv
// raster_addr_gen: frame-buffer raster scan FSM feeding a 3-stage address pipeline
module raster_addr_gen
  import raster_addr_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 480,
  parameter int COL_W = 10,
  parameter int ROW_W = 9,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic              out_phase,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done
);
  state_t state;
  mode_t mode_q;
  logic [ADDR_W-1:0] base_q;
  logic [ROW_W-1:0] cnt_row, s0_row;
  logic [COL_W-1:0] cnt_col, s0_col;
  logic s0_valid, s0_last, en, fire, col_end, row_end;
  always_comb begin
    en = !out_valid || out_ready;
    fire = out_valid && out_ready;
    col_end = cnt_col == COL_W'(H_ACTIVE - 1);
    row_end = cnt_row == ROW_W'(V_ACTIVE - 1);
    busy = state != IDLE;
  end
  // frame parameters survive abort; only rst clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_8BPP;
      base_q <= '0;
    end else if (state == IDLE && start && !abort) begin
      mode_q <= mode_of(mode);
      base_q <= base;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state <= IDLE;
      cnt_row <= '0;
      cnt_col <= '0;
      s0_valid <= 1'b0;
      s0_row <= '0;
      s0_col <= '0;
      s0_last <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= state == DRAIN && fire && out_last;
      if (en) begin
        s0_valid <= state == SCAN;
        s0_row <= cnt_row;
        s0_col <= cnt_col;
        s0_last <= state == SCAN && col_end && row_end;
      end
      if (state == IDLE && start) begin
        state <= SCAN;
        cnt_row <= '0;
        cnt_col <= '0;
      end else if (state == SCAN && en) begin
        cnt_col <= col_end ? '0 : cnt_col + 1'b1;
        cnt_row <= col_end ? cnt_row + 1'b1 : cnt_row;
        state <= col_end && row_end ? DRAIN : SCAN;
      end else if (state == DRAIN && fire && out_last) begin
        state <= IDLE;
      end
    end
  end
  addr_calc #(
    .H_ACTIVE(H_ACTIVE),
    .COL_W(COL_W),
    .ROW_W(ROW_W),
    .ADDR_W(ADDR_W)
  ) u_calc (
    .clk(clk),
    .clr(rst || abort),
    .en(en),
    .mode(mode_q),
    .base(base_q),
    .in_valid(s0_valid),
    .row(s0_row),
    .col(s0_col),
    .last(s0_last),
    .out_valid(out_valid),
    .addr(addr),
    .out_row(out_row),
    .out_col(out_col),
    .out_phase(out_phase),
    .out_last(out_last)
  );
endmodule
